// File: rtl/mod_n_counter_pkg.sv
// +---------------------------------------------------------------------+
// | mod_cnt_pkg : shared state encoding and reset constants             |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
`default_nettype none

package mod_cnt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_MOD   = 1;
  localparam state_t      RST_STATE = IDLE;
  localparam logic        RST_TC    = 1'b0;
  localparam logic        RST_ERR   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mod_n_counter_if.sv
// +---------------------------------------------------------------------+
// | mod_n_counter_if : control and status bundle of mod_n_counter       |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
`default_nettype none

interface mod_n_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             mod_load;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;
  logic             err;

  modport master (
    output en, start, stop, oneshot, mod_load, mod_val,
    input  cnt, tc, busy, err
  );

  modport slave (
    input  en, start, stop, oneshot, mod_load, mod_val,
    output cnt, tc, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/mod_n_counter_tick_gen.sv
// +---------------------------------------------------------------------+
// | tick_gen : prescaler issuing one qualified tick every PRESCALE clks |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] c_last = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] c_one  = PW'(1);

  logic [PW-1:0] r_pre;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pre <= '0;
    end else if (r_pre == c_last) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + c_one;
    end
  end

  assign tick = en & (r_pre == c_last);

endmodule

`default_nettype wire

// File: rtl/mod_n_counter.sv
// +---------------------------------------------------------------------+
// | mod_n_counter : runtime-modulus tick counter with registered tc     |
// | Optional prescaler: CLK_PRESCALE_EN.  Rev 1.0                       |
// +---------------------------------------------------------------------+
`default_nettype none

module mod_n_counter
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 8,
  parameter int PRESCALE    = 4
) (
  input wire logic        clk,
  input wire logic        rst,
  mod_n_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_default_mod = WIDTH'(DEFAULT_MOD);
  localparam logic [WIDTH-1:0] c_min_mod     = WIDTH'(MIN_MOD);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_active_mod;
  logic [WIDTH-1:0] r_pending;
  logic             r_pend_valid;
  logic             r_oneshot;
  logic             r_tc;
  logic             r_err;

  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_mod_next;
  logic [WIDTH-1:0] w_pend_next;
  logic             w_pv_next;
  logic             w_os_next;
  logic             w_tc_next;
  logic             w_err_next;
  logic             w_tick;
  logic             w_wrap;
  logic             w_load_ok;
  logic             w_clr;

  assign w_clr = (r_state == IDLE);

`ifdef CLK_PRESCALE_EN
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (bus.en),
    .tick (w_tick)
  );
`else
  assign w_tick = bus.en;
`endif

  // Comparing against active_mod-1 keeps N = 2^WIDTH-1 representable.
  assign w_wrap    = w_tick & (r_cnt == (r_active_mod - c_one));
  assign w_load_ok = bus.mod_load & (bus.mod_val >= c_min_mod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (bus.stop || (w_wrap && r_oneshot)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next  = r_cnt;
    w_tc_next   = 1'b0;
    w_mod_next  = r_active_mod;
    w_pend_next = r_pending;
    w_pv_next   = r_pend_valid;
    w_os_next   = r_oneshot;
    w_err_next  = r_err | (bus.mod_load & ~w_load_ok);
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_load_ok) begin
          w_mod_next = bus.mod_val;
        end
        if (bus.start && !bus.stop) begin
          w_os_next = bus.oneshot;
        end
      end
      RUN: begin
        // A stop on a wrap cycle swallows the whole wrap, including its tc.
        if (bus.stop) begin
          w_cnt_next = '0;
        end else if (w_wrap) begin
          w_cnt_next = '0;
          w_tc_next  = 1'b1;
          if (r_pend_valid) begin
            w_mod_next = r_pending;
            w_pv_next  = 1'b0;
          end
        end else if (w_tick) begin
          w_cnt_next = r_cnt + c_one;
        end
        if (w_load_ok) begin
          w_pend_next = bus.mod_val;
          w_pv_next   = 1'b1;
        end
      end
      default: w_cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_tc         <= RST_TC;
      r_active_mod <= c_default_mod;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_oneshot    <= 1'b0;
      r_err        <= RST_ERR;
    end else begin
      r_cnt        <= w_cnt_next;
      r_tc         <= w_tc_next;
      r_active_mod <= w_mod_next;
      r_pending    <= w_pend_next;
      r_pend_valid <= w_pv_next;
      r_oneshot    <= w_os_next;
      r_err        <= w_err_next;
    end
  end

  assign bus.cnt  = r_cnt;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == RUN);
  assign bus.err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_counter.sv
// +---------------------------------------------------------------------+
// | tb_mod_n_counter : scoreboard bench against a behavioural model     |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
`default_nettype none

module tb_mod_n_counter;

  localparam int W  = 8;
  localparam int DM = 8;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_n_counter_if #(.WIDTH(W)) bus ();

  mod_n_counter #(
    .WIDTH       (W),
    .DEFAULT_MOD (DM),
    .PRESCALE    (PS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: count value is the number of ticks since the period
  // began, reduced modulo the modulus; a wrap is when that reaches zero.
  bit m_run, m_tc, m_err, m_pv, m_os;
  int m_cnt, m_mod, m_pend, m_pre;

  task automatic model(input bit r, e, s, p, os, ld, input int mv);
    bit tick, was_run, ldok;
    if (r) begin
      m_run = 0; m_tc = 0; m_err = 0; m_pv = 0; m_os = 0;
      m_cnt = 0; m_mod = DM; m_pend = 0; m_pre = 0;
      return;
    end
    was_run = m_run;
    ldok    = ld && (mv != 0);
    if (ld && mv == 0) m_err = 1;
`ifdef CLK_PRESCALE_EN
    tick  = e && was_run && (m_pre == PS - 1);
    m_pre = was_run ? (m_pre + 1) % PS : 0;
`else
    tick = e;
`endif
    m_tc = 0;
    if (!was_run) begin
      m_cnt = 0;
      if (ldok) m_mod = mv;
      if (s && !p) begin
        m_run = 1;
        m_os  = os;
      end
    end else begin
      if (p) begin
        m_run = 0;
        m_cnt = 0;
      end else if (tick) begin
        m_cnt = (m_cnt + 1) % m_mod;
        if (m_cnt == 0) begin
          m_tc = 1;
          if (m_pv) begin
            m_mod = m_pend;
            m_pv  = 0;
          end
          if (m_os) m_run = 0;
        end
      end
      if (ldok) begin
        m_pend = mv;
        m_pv   = 1;
      end
    end
  endtask

  // Drive at negedge, model the posedge, queue the expected outputs.
  task automatic step(input bit r, e, s, p, os, ld, input int mv);
    obs_t ex;
    rst          = r;
    bus.en       = e;
    bus.start    = s;
    bus.stop     = p;
    bus.oneshot  = os;
    bus.mod_load = ld;
    bus.mod_val  = mv[W-1:0];
    @(posedge clk);
    model(r, e, s, p, os, ld, mv);
    ex.cnt  = m_cnt[W-1:0];
    ex.tc   = m_tc;
    ex.busy = m_run;
    ex.err  = m_err;
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(0, e, 0, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {bus.cnt, bus.tc, bus.busy, bus.err};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got cnt=%0d tc=%0b busy=%0b err=%0b want cnt=%0d tc=%0b busy=%0b err=%0b",
                   cyc, mon_a.cnt, mon_a.tc, mon_a.busy, mon_a.err,
                   mon_e.cnt, mon_e.tc, mon_e.busy, mon_e.err);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1; bus.en = 0; bus.start = 0; bus.stop = 0;
    bus.oneshot = 0; bus.mod_load = 0; bus.mod_val = '0;
    @(negedge clk);

    // Reset and default free-running period
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    run(40, 1);

    // Gated enable
    for (int i = 0; i < 48; i++) step(0, i % 2, 0, 0, 0, 0, 0);

    // One-shot with modulus 5 loaded in IDLE
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 5);
    step(0, 1, 1, 0, 1, 0, 0);
    run(12, 1);

    // Deferred load while running N=8, then a rejected zero load
    step(0, 1, 0, 0, 0, 1, 8);
    step(0, 1, 1, 0, 0, 0, 0);
    run(2, 1);
    step(0, 1, 0, 0, 0, 1, 3);
    run(1, 1);
    step(0, 1, 0, 0, 0, 1, 4);
    run(20, 1);
    step(0, 1, 0, 0, 0, 1, 0);
    run(10, 1);

    // Stop on a wrap cycle
    guard = 0;
    while (!(m_run && m_cnt == m_mod - 1) && guard < 300) begin
      step(0, 1, 0, 0, 0, 0, 0);
      guard++;
    end
    step(0, 1, 0, 1, 0, 0, 0);
    run(3, 1);

    // Start and stop together stays IDLE
    step(0, 1, 1, 1, 0, 0, 0);
    run(3, 1);

    // Reset mid-run at cnt=6 restores the default modulus
    step(0, 1, 0, 0, 0, 1, 20);
    step(0, 1, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt != 6 && guard < 300) begin
      step(0, 1, 0, 0, 0, 0, 0);
      guard++;
    end
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    run(20, 1);

    // Modulus 1: a wrap on every tick
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    run(12, 1);
    for (int i = 0; i < 8; i++) step(0, i % 3 != 0, 0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 12)));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised successor to the fixed mod-8 pulse counter.
- Counts ticks modulo a runtime-loadable modulus N and emits a registered one-cycle terminal-count pulse `tc` on each wrap.
- Supports free-running and one-shot modes, start/stop control, and modulus changes that take effect only at a wrap.
- Sits in the lab timing chain as the general event/period generator feeding display-scan and sequencing logic.

Parameters:
WIDTH, 8, counter and modulus width in bits
DEFAULT_MOD, 8, modulus after reset (must be 1..2^WIDTH-1)
PRESCALE, 4, clocks per tick when CLK_PRESCALE_EN is defined (>=1)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous reset, active-high
en  input  1  count enable, qualifies every tick
start  input  1  pulse: IDLE->RUN
stop  input  1  pulse: RUN->IDLE, count cleared
oneshot  input  1  sampled on start: 1 = stop after first wrap
mod_load  input  1  pulse: capture mod_val into pending modulus
mod_val  input  WIDTH  new modulus N
cnt  output  WIDTH  current count, 0..N-1
tc  output  1  one-cycle pulse, registered, on wrap
busy  output  1  high while in RUN
err  output  1  sticky: mod_load attempted with mod_val==0

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: state=IDLE, cnt=0, tc=0, busy=0, err=0.
  - Internal: active_mod=DEFAULT_MOD, pending_valid=0, oneshot_q=0, prescaler=0.
  - Reset mid-RUN discards the count and any pending modulus.
- tick = en (no macro); see Optional Feature.
- States: IDLE, RUN.
  - IDLE:
    - cnt held 0, tc=0.
    - start=1 -> RUN next cycle; oneshot_q<=oneshot; busy=1 from that cycle.
  - RUN, on a tick:
    - If cnt==active_mod-1: cnt<=0, tc<=1 (visible next cycle, one cycle wide). If pending_valid, active_mod<=pending and pending_valid<=0. If oneshot_q, go to IDLE.
    - Otherwise cnt<=cnt+1, tc<=0.
  - RUN, no tick: cnt held, tc<=0.
  - stop=1 in RUN -> IDLE, cnt<=0, tc<=0, even on a wrap cycle; in that case the wrap's tc is suppressed.
  - start and stop in the same cycle: stop wins.
  - start while already in RUN: ignored.
- Timing: start sampled at edge k, en=1 -> first tc high after edge k+N, then every N edges.
- N=1: every tick is a wrap; tc high continuously while en=1 in RUN.
- Counter arithmetic: unsigned, WIDTH bits; compare uses active_mod-1, so no overflow for N up to 2^WIDTH-1.
- Modulus load (mod_load=1):
  - mod_val==0: ignored, err<=1 (sticky until rst).
  - IDLE: active_mod<=mod_val immediately.
  - RUN: pending<=mod_val, pending_valid<=1. A later load before the wrap overwrites pending (last wins).
  - mod_load on the same cycle as a wrap: the old pending is applied at this wrap; the new value becomes pending.
- busy == (state==RUN), registered.

Optional Feature:
Macro: CLK_PRESCALE_EN.
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 on every clk while in RUN; it is held at 0 in IDLE.
  - tick = en & (prescaler==PRESCALE-1), so one tick every PRESCALE clocks.
  - Single clock domain; no derived clock.
  - tc is still one clk cycle wide.
- Undefined: no prescaler logic; tick = en.

Decomposition:
- Package mod_cnt_pkg:
  - state enum {IDLE, RUN};
  - localparam-style helpers for minimum modulus (1) and the reset constants.
- One sub-module, tick_gen: the prescaler. Instantiated only under CLK_PRESCALE_EN; ports clk, rst, clr, en, tick.

Test Plan:
- Reset/default (WIDTH=8, DEFAULT_MOD=8): rst 2 cycles, start, oneshot=0, en=1 -> tc pulses once every 8 cycles, first after edge k+8; cnt sequence 1..7,0.
- Gated enable: en toggles 1,0,1,0… -> tc every 16 clks; cnt holds on en=0 cycles; tc never 2 cycles wide.
- One-shot: mod_load 5 in IDLE, start with oneshot=1 -> exactly one tc at k+5, busy drops the same cycle tc rises, cnt=0 after.
- Deferred load: running N=8, mod_load 3 at cnt=2, then mod_load 4 at cnt=4 -> current period finishes at 8, following periods are 4; mod_load 0 -> err=1, period unchanged.
- Stop/race: stop on a wrap cycle -> no tc, IDLE, cnt=0; start+stop same cycle -> stays IDLE; rst mid-RUN at cnt=6 -> all outputs 0 next cycle, active_mod=8.
- CLK_PRESCALE_EN, PRESCALE=4, N=8, en=1: tc every 32 clks, one clk wide; N=1 -> tc every 4 clks.
